param_down_counter: RTL

- Parameterized loadable down-counter/timer, the count-down counterpart of the team's free-running up-counter (param_counter).
- Loads a start value and decrements once per enabled cycle to zero.
- Flags terminal count with a one-cycle done pulse.
- Operates one-shot or auto-reload; used as the programmable interval timer beside param_counter in the counter subsystem.

---
 rtl/param_down_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/param_down_counter.sv
// param_down_counter: loadable down-counter / interval timer.
// Loads a start value, decrements once per unpaused cycle and pulses done on
// terminal count. One-shot mode returns to IDLE; reload mode restarts from the
// latched value. periods counts completed periods and saturates at all-ones.
//
// start is a request, not a valid/ready pair. It is sampled only while busy=0
// (IDLE), and a high start in IDLE is always accepted on that clock edge.
// busy=1 plays the role of "not ready": start is ignored for as long as busy is high.
module param_down_counter #(
  parameter int MAX_COUNT = 255,
  parameter int PERIOD_W  = 8,
  localparam int W        = $clog2(MAX_COUNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        load_val,
  input  logic                reload_en,
  input  logic                pause,
  input  logic                abort,
  output logic [W-1:0]        count,
  output logic                busy,
  output logic                done,
  output logic [PERIOD_W-1:0] periods,
  output logic                state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNT);

  state_t                state, state_nxt;
  logic [W-1:0]          count_nxt;
  logic [W-1:0]          reload_val, reload_val_nxt;
  logic                  mode, mode_nxt;
  logic                  done_nxt;
  logic [PERIOD_W-1:0]   periods_nxt;
  logic [W-1:0]          eff_val;
  logic [PERIOD_W-1:0]   periods_inc;

  // Clamp the requested start value to the largest legal count; this can only
  // take effect when MAX_COUNT is below the all-ones value of the count width.
  assign eff_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Saturating increment of the completed-period counter.
  assign periods_inc = (periods == '1) ? periods : periods + PERIOD_W'(1);

  assign busy      = (state == RUN);
  assign state_dbg = state;

  // State and datapath registers; reset clears everything, including latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_val <= '0;
      mode       <= 1'b0;
      done       <= 1'b0;
      periods    <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_val <= reload_val_nxt;
      mode       <= mode_nxt;
      done       <= done_nxt;
      periods    <= periods_nxt;
    end
  end

  // Next-state and next-output logic. In RUN: abort beats pause beats decrement.
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    reload_val_nxt = reload_val;
    mode_nxt       = mode;
    done_nxt       = 1'b0;
    periods_nxt    = periods;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (load_val == '0) begin
            // A zero-length period completes on the spot without entering RUN.
            count_nxt   = '0;
            done_nxt    = 1'b1;
            periods_nxt = PERIOD_W'(1);
          end else begin
            count_nxt      = eff_val;
            reload_val_nxt = eff_val;
            mode_nxt       = reload_en;
            periods_nxt    = '0;
            state_nxt      = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (pause) begin
          count_nxt = count;
        end else if (count > W'(1)) begin
          count_nxt = count - W'(1);
        end else begin
          // Terminal count: flag it, then reload or fall back to IDLE.
          done_nxt    = 1'b1;
          periods_nxt = periods_inc;
          if (mode) begin
            count_nxt = reload_val;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule
